// File: rtl/tff_seq_pkg.sv
// ============================================================================
// Module   : tff_seq_pkg
// Purpose  : Shared state encoding for the t_ff count sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tff_seq_pkg;

   localparam int TFF_SEQ_STATE_W = 2;

   typedef enum logic [TFF_SEQ_STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } tff_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/t_ff.sv
// ============================================================================
// Module   : t_ff
// Purpose  : Toggle flip-flop with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q,
   output logic qbar
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= 1'b0;
      else if (t)
         q <= ~q;
   end

   assign qbar = ~q;

endmodule

`default_nettype wire

// File: rtl/tff_count_sequencer.sv
// ============================================================================
// Module   : tff_count_sequencer
// Purpose  : FSM driving a bank of t_ff cells as an up-counter to a latched
//            limit, with pause/abort. Optional macro TFF_SEQ_AUTORELOAD_EN
//            turns the terminal count into an auto-reload with a wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_count_sequencer
   import tff_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   tff_seq_state_t   r_state;
   tff_seq_state_t   w_state_nxt;
   logic [WIDTH-1:0] r_limit;
   logic             w_latch;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_qbar_unused;
   logic             w_at_limit;
   logic             r_busy;
   logic             r_done;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_wrap_nxt;

   // Increment toggles: a bit flips when every lower bit is already one.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_inc
         if (gi == 0) begin : g_lsb
            assign w_inc[gi] = 1'b1;
         end else begin : g_upper
            assign w_inc[gi] = &count[gi-1:0];
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bank
         t_ff u_t_ff (
            .clk  (clk),
            .rst  (rst),
            .t    (w_t[gi]),
            .q    (count[gi]),
            .qbar (w_qbar_unused[gi])
         );
      end
   endgenerate

   assign w_at_limit = (count == r_limit);

   always_comb begin
      w_state_nxt = r_state;
      w_t         = '0;
      w_latch     = 1'b0;
      w_wrap_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_latch = 1'b1;
               w_t     = count;
`ifdef TFF_SEQ_AUTORELOAD_EN
               w_state_nxt = RUN;
`else
               w_state_nxt = (load_val == '0) ? DONE : RUN;
`endif
            end
         end
         RUN: begin
            if (stop) begin
               w_state_nxt = HOLD;
            end else if (w_at_limit) begin
`ifdef TFF_SEQ_AUTORELOAD_EN
               w_t        = count;
               w_wrap_nxt = 1'b1;
`else
               w_state_nxt = DONE;
`endif
            end else begin
               w_t = w_inc;
            end
         end
         HOLD: begin
            if (stop) begin
               w_t         = count;
               w_state_nxt = IDLE;
            end else if (start) begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they never glitch on inputs.
   assign w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == HOLD);
   assign w_done_nxt = (w_state_nxt == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_limit <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_latch)
            r_limit <= load_val;
      end
   end

`ifdef TFF_SEQ_AUTORELOAD_EN
   logic r_wrap;

   always_ff @(posedge clk) begin
      if (rst)
         r_wrap <= 1'b0;
      else
         r_wrap <= w_wrap_nxt;
   end

   assign wrap = r_wrap;
`else
   logic w_wrap_unused;

   assign w_wrap_unused = w_wrap_nxt;
   assign wrap          = 1'b0;
`endif

   assign busy = r_busy;
   assign done = r_done;

endmodule

`default_nettype wire
